// File: rtl/hdr_ddr_cmd_rx_tgt.sv
// HDR-DDR target command-word receiver.
// Deserializes preamble, 16-bit command word and parity; watches for HDR Exit.
module hdr_ddr_cmd_rx_tgt #(
    parameter logic [6:0] BROADCAST_ADDR = 7'h7E
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_engine_en,
    input  logic       i_scl,
    input  logic       i_sda,
    input  logic       i_scl_pos_edge,
    input  logic       i_scl_neg_edge,
    input  logic [6:0] i_dyn_addr,
    output logic       o_cmd_valid,
    output logic       o_rnw,
    output logic [6:0] o_cmd_code,
    output logic [6:0] o_tgt_addr,
    output logic       o_addr_match,
    output logic       o_preamble_err,
    output logic       o_parity_err,
    output logic       o_hdr_exit,
    output logic       o_engine_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_PAYLOAD,
        S_PARITY,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pre_q, pre_d;
    logic [15:0] w_q, w_d;
    logic        pa1_q, pa1_d;
    logic        sda_q;
    logic [2:0]  exit_cnt_q, exit_cnt_d;

    logic        rnw_d;
    logic [6:0]  cmd_d;
    logic [6:0]  addr_d;
    logic        match_d;
    logic        perr_d;
    logic        parerr_d;
    logic        valid_d;
    logic        done_d;

    logic        slot;
    logic        sda_fall;
    logic        exit_hit;
    logic        abort;
    logic        pa1_exp;
    logic        pa0_exp;
    logic        mismatch;

    // Bit-slot strobe, SDA fall detection and expected parity of the word
    always_comb begin
        slot     = i_scl_pos_edge ^ i_scl_neg_edge;
        sda_fall = sda_q & ~i_sda & ~i_scl;
        exit_hit = (state_q != S_IDLE) && sda_fall && (exit_cnt_q == 3'd3);
        abort    = exit_hit || ((state_q != S_IDLE) && !i_engine_en);
        pa1_exp  = w_q[15] ^ w_q[13] ^ w_q[11] ^ w_q[9]
                 ^ w_q[7] ^ w_q[5] ^ w_q[3] ^ w_q[1];
        pa0_exp  = ~(w_q[14] ^ w_q[12] ^ w_q[10] ^ w_q[8]
                 ^ w_q[6] ^ w_q[4] ^ w_q[2] ^ w_q[0]);
    end

    // HDR Exit counter: SDA falls while SCL low, cleared by SCL high
    always_comb begin
        exit_cnt_d = exit_cnt_q;
        if (state_q == S_IDLE || i_scl) begin
            exit_cnt_d = 3'd0;
        end else if (sda_fall) begin
            exit_cnt_d = exit_cnt_q + 3'd1;
        end
    end

    // Frame FSM next-state and output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        w_d      = w_q;
        pa1_d    = pa1_q;
        rnw_d    = o_rnw;
        cmd_d    = o_cmd_code;
        addr_d   = o_tgt_addr;
        match_d  = o_addr_match;
        perr_d   = o_preamble_err;
        parerr_d = o_parity_err;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        mismatch = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_engine_en) begin
                    state_d  = S_PREAMBLE;
                    cnt_d    = 4'd0;
                    perr_d   = 1'b0;
                    parerr_d = 1'b0;
                end
            end
            S_PREAMBLE: begin
                if (slot) begin
                    if (!cnt_q[0]) begin
                        pre_d = i_sda;
                        cnt_d = 4'd1;
                    end else begin
                        cnt_d = 4'd0;
                        if ({pre_q, i_sda} == 2'b01) begin
                            state_d = S_PAYLOAD;
                        end else begin
                            perr_d  = 1'b1;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                if (slot) begin
                    w_d   = {w_q[14:0], i_sda};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (slot) begin
                    if (!cnt_q[0]) begin
                        pa1_d = i_sda;
                        cnt_d = 4'd1;
                    end else begin
                        cnt_d    = 4'd0;
                        mismatch = (pa1_q != pa1_exp) || (i_sda != pa0_exp);
                        rnw_d    = w_q[15];
                        cmd_d    = w_q[14:8];
                        addr_d   = w_q[7:1];
                        match_d  = (w_q[7:1] == i_dyn_addr)
                                || (w_q[7:1] == BROADCAST_ADDR);
                        parerr_d = mismatch;
                        valid_d  = ~mismatch;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Exit or enable loss drops the frame and keeps prior results
        if (abort) begin
            state_d  = S_IDLE;
            cnt_d    = 4'd0;
            rnw_d    = o_rnw;
            cmd_d    = o_cmd_code;
            addr_d   = o_tgt_addr;
            match_d  = o_addr_match;
            perr_d   = o_preamble_err;
            parerr_d = o_parity_err;
            valid_d  = 1'b0;
            done_d   = 1'b0;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= 4'd0;
            pre_q          <= 1'b0;
            w_q            <= 16'h0000;
            pa1_q          <= 1'b0;
            sda_q          <= 1'b1;
            exit_cnt_q     <= 3'd0;
            o_cmd_valid    <= 1'b0;
            o_rnw          <= 1'b0;
            o_cmd_code     <= 7'h00;
            o_tgt_addr     <= 7'h00;
            o_addr_match   <= 1'b0;
            o_preamble_err <= 1'b0;
            o_parity_err   <= 1'b0;
            o_hdr_exit     <= 1'b0;
            o_engine_done  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pre_q          <= pre_d;
            w_q            <= w_d;
            pa1_q          <= pa1_d;
            sda_q          <= i_sda;
            exit_cnt_q     <= exit_cnt_d;
            o_cmd_valid    <= valid_d;
            o_rnw          <= rnw_d;
            o_cmd_code     <= cmd_d;
            o_tgt_addr     <= addr_d;
            o_addr_match   <= match_d;
            o_preamble_err <= perr_d;
            o_parity_err   <= parerr_d;
            o_hdr_exit     <= exit_hit;
            o_engine_done  <= done_d;
        end
    end

endmodule
